pipelined_adder_x: RTL and testbench
====================================

# pipelined_adder_x

Parametrised, pipelined ripple adder/subtractor for the adder library. It splits a WIDTH-bit add into STAGES segments of SEG bits and registers the inter-segment carry between stages, so the carry chain per cycle is SEG bits long. It accepts one operand pair per cycle under a valid/ready handshake and sits between operand producers and any registered datapath consumer that needs wide sums at high clock rates.

## Interface
- WIDTH, 32, operand and sum width; must be a multiple of SEG.
- SEG, 8, bits added per pipeline stage; 1 ≤ SEG ≤ WIDTH.
- STAGES, WIDTH/SEG (derived localparam, not overridable), pipeline depth.
- clk1  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- X  input  WIDTH  operand A.
- Y  input  WIDTH  operand B.
- Carryin  input  1  carry into bit 0; used only when sub=0.
- sub  input  1  0: X+Y+Carryin; 1: X−Y, computed as X+~Y+1.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result.
- Sum  output  WIDTH  result, modulo 2^WIDTH.
- Carryout  output  1  carry out of bit WIDTH−1; when sub=1, 1 means no borrow.
- Overflow  output  1  two's-complement signed overflow.

## Operation
- Accept: in_valid & in_ready on a rising edge.
- in_ready = ~rst & (~out_valid | out_ready).
- Global advance enable adv = ~out_valid | out_ready. All stage registers load only when adv=1 and otherwise hold.
- Stage 1 inverts Y when sub=1 and selects carry-in = sub ? 1 : Carryin. It adds segment 0 and registers the partial sum, the carry, the remaining operand segments and the valid bit.
- Stage i (2..STAGES) adds segment i−1 using the registered carry from stage i−1. It forwards the already-computed lower sum bits and drops the consumed operand bits.
- Stage STAGES register is the output: Sum, Carryout = final segment carry, and Overflow = carry into bit WIDTH−1 XOR Carryout.
- A valid bit travels with each beat. Empty slots (bubbles) propagate as valid=0 and are never emitted.
- Reset: all valid bits, Sum, Carryout and Overflow are 0, and all pipeline data registers are cleared. in_ready is 0 while rst=1.
- Reset mid-operation discards every in-flight beat. No partial result is ever presented.
- Behaviour at widths: SEG=WIDTH gives STAGES=1, a single registered adder. SEG=1 gives STAGES=WIDTH.
- Elaboration error if WIDTH % SEG ≠ 0.

## Timing
- Latency: a beat accepted at edge k appears with out_valid=1 after edge k+STAGES−1, i.e. STAGES register stages.
- Throughput: one beat per cycle while out_ready=1.
- Stall: out_valid=1 & out_ready=0 freezes the whole pipeline and holds in_ready=0. Sum, Carryout and Overflow stay stable until accepted.
- Simultaneous output accept and input accept in the same cycle is legal, giving no lost cycle.
- Bubbles are collapsed only at the output stage (adv when out_valid=0). There is no internal compaction.
- Combinational paths: in_ready depends on out_ready (one gate). There is no other input→output combinational path.
- Critical path: one SEG-bit ripple plus the stage-1 Y inversion mux.

## Structure
- Shared package adder_pkg holds:
  - default WIDTH/SEG constants;
  - the STAGES derivation function;
  - the op-mode encoding constants OP_ADD=0 and OP_SUB=1.
- Natural sub-module: adder_seg_stage. It is one SEG-bit ripple segment with registered sum, carry and valid, reusing the existing 1-bit full-adder cell internally.
- The top instantiates STAGES copies in a generate loop and handles operand/sum skew registers.

## Test plan
- Add, WIDTH=32, SEG=8, no stalls: X=0xFFFFFFFF, Y=0x00000001, Carryin=0 → Sum=0x00000000, Carryout=1, Overflow=0, exactly 4 cycles after accept.
- Subtract with signed overflow: sub=1, X=0x80000000, Y=0x00000001 → Sum=0x7FFFFFFF, Carryout=1, Overflow=1. Then X=0x00000000, Y=0x00000001 → Sum=0xFFFFFFFF, Carryout=0 (borrow), Overflow=0.
- Back-to-back streaming: 100 random beats with in_valid=1 and out_ready=1 every cycle → one result per cycle, in order, matching (X±Y+cin) mod 2^32.
- Backpressure: out_ready=0 for 5 cycles while beats are in flight → in_ready=0, outputs held stable, no beat lost or duplicated after out_ready returns to 1.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight → out_valid=0 and all outputs 0 the next cycle, no stale result emitted, a new beat gives the correct result 4 cycles later.
- Parameter sweep: (WIDTH,SEG) = (8,8), (8,1), (16,4) with exhaustive or random operands → latency equals STAGES and results are correct.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the adder library: default geometry, stage count
// derivation, operation encoding and the 1-bit full-adder cell.
package adder_pkg;

    localparam int ADDER_WIDTH = 32;
    localparam int ADDER_SEG   = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Number of SEG-bit segments needed to cover WIDTH bits.
    function automatic int adder_stages(input int width, input int seg);
        return (seg > 0) ? (width / seg) : 1;
    endfunction

    // 1-bit full-adder cell, result packed as {carry, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
    endfunction

endpackage

// File: rtl/adder_seg_stage.sv
// One SEG-bit ripple segment of the pipelined adder with registered sum,
// carry-out and valid. All registers advance together on en.
module adder_seg_stage
    import adder_pkg::*;
#(
    parameter int SEG = ADDER_SEG
) (
    input  logic           clk1,
    input  logic           rst,
    input  logic           en,
    input  logic           vin,
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic           vout,
    output logic [SEG-1:0] s,
    output logic           cout
);

    logic [SEG:0]   c;
    logic [SEG-1:0] s_d;

    // Ripple the carry through SEG full-adder cells.
    always_comb begin
        c    = '0;
        s_d  = '0;
        c[0] = cin;
        for (int i = 0; i < SEG; i++) begin
            {c[i+1], s_d[i]} = full_add(a[i], b[i], c[i]);
        end
    end

    // Capture the segment result when the pipeline advances.
    always_ff @(posedge clk1) begin
        if (rst) begin
            vout <= 1'b0;
            s    <= '0;
            cout <= 1'b0;
        end else if (en) begin
            vout <= vin;
            s    <= s_d;
            cout <= c[SEG];
        end
    end

endmodule

// File: rtl/pipelined_adder_x.sv
// Pipelined adder/subtractor: WIDTH bits split into STAGES segments of SEG
// bits, carry registered between segments. Operands not yet consumed and sum
// bits already produced travel alongside the carry in skew registers.
module pipelined_adder_x
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int SEG   = ADDER_SEG
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Carryin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Carryout,
    output logic             Overflow
);

    localparam int STAGES = adder_stages(WIDTH, SEG);

    if ((SEG < 1) || (SEG > WIDTH) || ((WIDTH % SEG) != 0)) begin : g_param_err
        $error("pipelined_adder_x: WIDTH must be a non-zero multiple of SEG");
    end

    logic             adv;
    logic [WIDTH-1:0] y_op;
    logic             cin0;
    logic             msb_ab_d;
    logic             msb_ab_q;

    // The whole pipeline moves unless a finished result is waiting.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = ~rst & adv;
    assign y_op     = (sub == OP_ADD) ? Y : ~Y;
    assign cin0     = (sub == OP_SUB) ? 1'b1 : Carryin;

    for (genvar g = 0; g < STAGES; g++) begin : stg
        logic [SEG-1:0]         a;
        logic [SEG-1:0]         b;
        logic                   cin;
        logic                   vin;
        logic [SEG-1:0]         s;
        logic                   cout;
        logic                   vout;
        logic [(g+1)*SEG-1:0]   sum_all;

        if (g == 0) begin : g_first
            assign a       = X[SEG-1:0];
            assign b       = y_op[SEG-1:0];
            assign cin     = cin0;
            assign vin     = in_valid;
            assign sum_all = s;
        end else begin : g_next
            logic [g*SEG-1:0] lo;

            assign a       = stg[g-1].g_rem.xr[SEG-1:0];
            assign b       = stg[g-1].g_rem.yr[SEG-1:0];
            assign cin     = stg[g-1].cout;
            assign vin     = stg[g-1].vout;
            assign sum_all = {s, lo};

            // Carry the lower sum bits forward alongside this segment.
            always_ff @(posedge clk1) begin
                if (rst) begin
                    lo <= '0;
                end else if (adv) begin
                    lo <= stg[g-1].sum_all;
                end
            end
        end

        // Operand bits still to be added by later stages.
        if (g < STAGES - 1) begin : g_rem
            logic [WIDTH-(g+1)*SEG-1:0] xr;
            logic [WIDTH-(g+1)*SEG-1:0] yr;
            logic [WIDTH-(g+1)*SEG-1:0] xr_d;
            logic [WIDTH-(g+1)*SEG-1:0] yr_d;

            if (g == 0) begin : g_src_in
                assign xr_d = X[WIDTH-1:SEG];
                assign yr_d = y_op[WIDTH-1:SEG];
            end else begin : g_src_prev
                assign xr_d = stg[g-1].g_rem.xr[WIDTH-g*SEG-1:SEG];
                assign yr_d = stg[g-1].g_rem.yr[WIDTH-g*SEG-1:SEG];
            end

            // Shift out the consumed segment and hold the rest.
            always_ff @(posedge clk1) begin
                if (rst) begin
                    xr <= '0;
                    yr <= '0;
                end else if (adv) begin
                    xr <= xr_d;
                    yr <= yr_d;
                end
            end
        end

        adder_seg_stage #(
            .SEG (SEG)
        ) u_seg (
            .clk1 (clk1),
            .rst  (rst),
            .en   (adv),
            .vin  (vin),
            .a    (a),
            .b    (b),
            .cin  (cin),
            .vout (vout),
            .s    (s),
            .cout (cout)
        );
    end

    // Operand MSBs of the last segment: with the registered sum MSB they
    // recover the carry into bit WIDTH-1 for the overflow flag.
    assign msb_ab_d = stg[STAGES-1].a[SEG-1] ^ stg[STAGES-1].b[SEG-1];

    // Keep the MSB parity aligned with the output stage register.
    always_ff @(posedge clk1) begin
        if (rst) begin
            msb_ab_q <= 1'b0;
        end else if (adv) begin
            msb_ab_q <= msb_ab_d;
        end
    end

    assign out_valid = stg[STAGES-1].vout;
    assign Sum       = stg[STAGES-1].sum_all;
    assign Carryout  = stg[STAGES-1].cout;
    assign Overflow  = msb_ab_q ^ Sum[WIDTH-1] ^ Carryout;

endmodule

// File: tb/tb_pipelined_adder_x.sv
// Self-checking bench for pipelined_adder_x: a 32/8 instance driven through
// a scoreboard, plus 8/8, 8/1 and 16/4 instances for the geometry sweep.
module tb_pipelined_adder_x;

    localparam int ST = 4;
    localparam int NS = 48;

    typedef struct {
        logic [31:0] sum;
        logic        co;
        logic        ov;
        int          cyc;
    } beat_t;

    logic        clk1;
    logic        rst;
    logic        in_valid, in_ready, carryin, sub, out_valid, out_ready, carryout, overflow;
    logic [31:0] x, y, sum;

    logic        a8_in_valid, a8_in_ready, a8_cin, a8_sub, a8_out_valid, a8_co, a8_ov;
    logic [7:0]  a8_x, a8_y, a8_sum;
    logic        b8_in_valid, b8_in_ready, b8_cin, b8_sub, b8_out_valid, b8_co, b8_ov;
    logic [7:0]  b8_x, b8_y, b8_sum;
    logic        c16_in_valid, c16_in_ready, c16_cin, c16_sub, c16_out_valid, c16_co, c16_ov;
    logic [15:0] c16_x, c16_y, c16_sum;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];

    pipelined_adder_x #(.WIDTH(32), .SEG(8)) dut (
        .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .X(x), .Y(y), .Carryin(carryin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(sum), .Carryout(carryout), .Overflow(overflow)
    );

    pipelined_adder_x #(.WIDTH(8), .SEG(8)) dut_a8 (
        .clk1(clk1), .rst(rst), .in_valid(a8_in_valid), .in_ready(a8_in_ready),
        .X(a8_x), .Y(a8_y), .Carryin(a8_cin), .sub(a8_sub),
        .out_valid(a8_out_valid), .out_ready(1'b1),
        .Sum(a8_sum), .Carryout(a8_co), .Overflow(a8_ov)
    );

    pipelined_adder_x #(.WIDTH(8), .SEG(1)) dut_b8 (
        .clk1(clk1), .rst(rst), .in_valid(b8_in_valid), .in_ready(b8_in_ready),
        .X(b8_x), .Y(b8_y), .Carryin(b8_cin), .sub(b8_sub),
        .out_valid(b8_out_valid), .out_ready(1'b1),
        .Sum(b8_sum), .Carryout(b8_co), .Overflow(b8_ov)
    );

    pipelined_adder_x #(.WIDTH(16), .SEG(4)) dut_c16 (
        .clk1(clk1), .rst(rst), .in_valid(c16_in_valid), .in_ready(c16_in_ready),
        .X(c16_x), .Y(c16_y), .Carryin(c16_cin), .sub(c16_sub),
        .out_valid(c16_out_valid), .out_ready(1'b1),
        .Sum(c16_sum), .Carryout(c16_co), .Overflow(c16_ov)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    // Reference: {overflow, carry, sum} of a w-bit add/subtract, overflow
    // taken from operand and result signs.
    function automatic logic [33:0] ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                            input logic ci, input logic op);
        logic [63:0] mask, aa, bb, r;
        logic        co, ov;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'd0, a} & mask;
        bb   = (op ? ~{32'd0, b} : {32'd0, b}) & mask;
        r    = aa + bb + {63'd0, (op ? 1'b1 : ci)};
        co   = r[w];
        ov   = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
        return {ov, co, r[31:0] & mask[31:0]};
    endfunction

    task automatic drive_rand();
        x       = $urandom;
        y       = $urandom;
        carryin = 1'(($urandom));
        sub     = 1'(($urandom));
    endtask

    // One clock: record accepted inputs (as expectations) and accepted
    // outputs (as observations); a reset edge discards in-flight beats.
    task automatic tick();
        logic        acc, oacc, in_rst;
        logic [33:0] r;
        beat_t       bt;
        #1;
        acc    = in_valid & in_ready;
        oacc   = out_valid & out_ready;
        in_rst = rst;
        if (acc === 1'b1) begin
            r      = ref_add(32, x, y, carryin, sub);
            bt.sum = r[31:0];
            bt.co  = r[32];
            bt.ov  = r[33];
            bt.cyc = cyc;
            exp_q.push_back(bt);
        end
        if (oacc === 1'b1 && in_rst !== 1'b1) begin
            bt.sum = sum;
            bt.co  = carryout;
            bt.ov  = overflow;
            bt.cyc = cyc;
            obs_q.push_back(bt);
        end
        @(negedge clk1);
        cyc++;
        if (in_rst === 1'b1) begin
            while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && obs_q.size() < exp_q.size(); i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        drive_rand();
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        checks++;
        if ({out_valid, sum, carryout, overflow} !== 35'd0) begin
            errors++; $display("FAIL reset_outputs: got v=%b sum=%h co=%b ov=%b want all 0",
                               out_valid, sum, carryout, overflow);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL release_in_ready: got %b want 1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL release_out_valid: got %b want 0", out_valid);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_add_latency();
        int    n;
        beat_t e, o;
        x = 32'hFFFF_FFFF; y = 32'h0000_0001; carryin = 1'b0; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        checks++;
        if (exp_q.size() != 1) begin
            errors++; $display("FAIL add_accept: got %0d accepted want 1", exp_q.size());
        end
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != ST) begin
            errors++; $display("FAIL add_latency: got %0d edges want %0d", n, ST);
        end
        checks++;
        if ({sum, carryout, overflow} !== {32'h0000_0000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL add_result: got sum=%h co=%b ov=%b want 00000000/1/0",
                               sum, carryout, overflow);
        end
        drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL add_count: got %0d results want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if ({o.sum, o.co, o.ov} !== {e.sum, e.co, e.ov}) begin
                errors++; $display("FAIL add_sb: got %h/%b/%b want %h/%b/%b", o.sum, o.co, o.ov, e.sum, e.co, e.ov);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_sub_overflow();
        beat_t e, o;
        sub = 1'b1; carryin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        x = 32'h8000_0000; y = 32'h0000_0001;
        tick();
        x = 32'h0000_0000; y = 32'h0000_0001;
        tick();
        drain();
        checks++;
        if (obs_q.size() != 2) begin
            errors++; $display("FAIL sub_count: got %0d results want 2", obs_q.size());
        end else begin
            checks++;
            if ({obs_q[0].sum, obs_q[0].co, obs_q[0].ov} !== {32'h7FFF_FFFF, 1'b1, 1'b1}) begin
                errors++; $display("FAIL sub_ovf: got %h/%b/%b want 7fffffff/1/1",
                                   obs_q[0].sum, obs_q[0].co, obs_q[0].ov);
            end
            checks++;
            if ({obs_q[1].sum, obs_q[1].co, obs_q[1].ov} !== {32'hFFFF_FFFF, 1'b0, 1'b0}) begin
                errors++; $display("FAIL sub_borrow: got %h/%b/%b want ffffffff/0/0",
                                   obs_q[1].sum, obs_q[1].co, obs_q[1].ov);
            end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if ({o.sum, o.co, o.ov} !== {e.sum, e.co, e.ov}) begin
                errors++; $display("FAIL sub_sb: got %h/%b/%b want %h/%b/%b", o.sum, o.co, o.ov, e.sum, e.co, e.ov);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        int    gaps;
        beat_t e, o;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            drive_rand();
            tick();
        end
        checks++;
        if (exp_q.size() != 100) begin
            errors++; $display("FAIL b2b_accepts: got %0d want 100", exp_q.size());
        end
        drain();
        gaps = 0;
        for (int i = 1; i < obs_q.size(); i++) begin
            if (obs_q[i].cyc != obs_q[i-1].cyc + 1) gaps++;
        end
        checks++;
        if (gaps != 0 || obs_q.size() != 100) begin
            errors++; $display("FAIL b2b_rate: got %0d results with %0d gaps want 100 with 0", obs_q.size(), gaps);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if ({o.sum, o.co, o.ov} !== {e.sum, e.co, e.ov}) begin
                errors++; $display("FAIL b2b_sb: got %h/%b/%b want %h/%b/%b", o.sum, o.co, o.ov, e.sum, e.co, e.ov);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_backpressure();
        logic [33:0] snap;
        beat_t       e, o;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_rand();
            tick();
        end
        out_ready = 1'b0;
        snap = {sum, carryout, overflow};
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_start_valid: got %b want 1", out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            drive_rand();
            in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready);
            end
            tick();
            checks++;
            if ({out_valid, sum, carryout, overflow} !== {1'b1, snap}) begin
                errors++; $display("FAIL bp_hold: got v=%b %h/%b/%b want v=1 %h/%b/%b",
                                   out_valid, sum, carryout, overflow, snap[33:2], snap[1], snap[0]);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            drive_rand();
            tick();
        end
        drain();
        checks++;
        if (exp_q.size() != 10 || obs_q.size() != 10) begin
            errors++; $display("FAIL bp_count: got %0d accepted %0d results want 10 and 10", exp_q.size(), obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if ({o.sum, o.co, o.ov} !== {e.sum, e.co, e.ov}) begin
                errors++; $display("FAIL bp_sb: got %h/%b/%b want %h/%b/%b", o.sum, o.co, o.ov, e.sum, e.co, e.ov);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        int    stale, n;
        beat_t e, o;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            tick();
        end
        rst = 1'b1;
        drive_rand();
        tick();
        checks++;
        if ({out_valid, sum, carryout, overflow} !== 35'd0) begin
            errors++; $display("FAIL midrst_outputs: got v=%b sum=%h co=%b ov=%b want all 0",
                               out_valid, sum, carryout, overflow);
        end
        rst = 1'b0; in_valid = 1'b0;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++; $display("FAIL midrst_stale: got %0d valid cycles want 0", stale);
        end
        in_valid = 1'b1;
        drive_rand();
        tick();
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != ST) begin
            errors++; $display("FAIL midrst_latency: got %0d edges want %0d", n, ST);
        end
        drain();
        checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            errors++; $display("FAIL midrst_count: got %0d results %0d expected want 1 and 1", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if ({o.sum, o.co, o.ov} !== {e.sum, e.co, e.ov}) begin
                errors++; $display("FAIL midrst_sb: got %h/%b/%b want %h/%b/%b", o.sum, o.co, o.ov, e.sum, e.co, e.ov);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    // Streams NS beats into each sweep instance; output at edge t must be
    // beat t-(STAGES-1), which checks both latency and value.
    task automatic test_sweep();
        logic [33:0] ea [NS];
        logic [33:0] eb [NS];
        logic [33:0] ec [NS];
        int          j;
        logic        want;
        for (int t = 0; t < NS + 12; t++) begin
            if (t < NS) begin
                a8_x = 8'($urandom); a8_y = 8'($urandom); a8_cin = 1'($urandom); a8_sub = 1'($urandom);
                b8_x = 8'($urandom); b8_y = 8'($urandom); b8_cin = 1'($urandom); b8_sub = 1'($urandom);
                c16_x = 16'($urandom); c16_y = 16'($urandom); c16_cin = 1'($urandom); c16_sub = 1'($urandom);
                ea[t] = ref_add(8, {24'd0, a8_x}, {24'd0, a8_y}, a8_cin, a8_sub);
                eb[t] = ref_add(8, {24'd0, b8_x}, {24'd0, b8_y}, b8_cin, b8_sub);
                ec[t] = ref_add(16, {16'd0, c16_x}, {16'd0, c16_y}, c16_cin, c16_sub);
                a8_in_valid = 1'b1; b8_in_valid = 1'b1; c16_in_valid = 1'b1;
            end else begin
                a8_in_valid = 1'b0; b8_in_valid = 1'b0; c16_in_valid = 1'b0;
            end
            #1;
            checks++;
            if ({a8_in_ready, b8_in_ready, c16_in_ready} !== 3'b111) begin
                errors++; $display("FAIL sweep_in_ready: got %b want 111", {a8_in_ready, b8_in_ready, c16_in_ready});
            end
            @(negedge clk1);

            j = t;
            want = (j >= 0) && (j < NS);
            checks++;
            if (a8_out_valid !== want) begin
                errors++; $display("FAIL sweep_8_8_valid t=%0d: got %b want %b", t, a8_out_valid, want);
            end else if (want) begin
                checks++;
                if ({a8_ov, a8_co, a8_sum} !== {ea[j][33:32], ea[j][7:0]}) begin
                    errors++; $display("FAIL sweep_8_8 beat %0d: got %b/%b/%h want %b/%b/%h",
                                       j, a8_ov, a8_co, a8_sum, ea[j][33], ea[j][32], ea[j][7:0]);
                end
            end

            j = t - 7;
            want = (j >= 0) && (j < NS);
            checks++;
            if (b8_out_valid !== want) begin
                errors++; $display("FAIL sweep_8_1_valid t=%0d: got %b want %b", t, b8_out_valid, want);
            end else if (want) begin
                checks++;
                if ({b8_ov, b8_co, b8_sum} !== {eb[j][33:32], eb[j][7:0]}) begin
                    errors++; $display("FAIL sweep_8_1 beat %0d: got %b/%b/%h want %b/%b/%h",
                                       j, b8_ov, b8_co, b8_sum, eb[j][33], eb[j][32], eb[j][7:0]);
                end
            end

            j = t - 3;
            want = (j >= 0) && (j < NS);
            checks++;
            if (c16_out_valid !== want) begin
                errors++; $display("FAIL sweep_16_4_valid t=%0d: got %b want %b", t, c16_out_valid, want);
            end else if (want) begin
                checks++;
                if ({c16_ov, c16_co, c16_sum} !== {ec[j][33:32], ec[j][15:0]}) begin
                    errors++; $display("FAIL sweep_16_4 beat %0d: got %b/%b/%h want %b/%b/%h",
                                       j, c16_ov, c16_co, c16_sum, ec[j][33], ec[j][32], ec[j][15:0]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; carryin = 1'b0; sub = 1'b0;
        a8_in_valid = 1'b0; a8_x = '0; a8_y = '0; a8_cin = 1'b0; a8_sub = 1'b0;
        b8_in_valid = 1'b0; b8_x = '0; b8_y = '0; b8_cin = 1'b0; b8_sub = 1'b0;
        c16_in_valid = 1'b0; c16_x = '0; c16_y = '0; c16_cin = 1'b0; c16_sub = 1'b0;
        @(negedge clk1);
        test_reset();
        test_add_latency();
        test_sub_overflow();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
